nf10_eee_lpi_port_lookup: RTL and testbench

Parametrised Energy-Efficient-Ethernet (802.3az) output stage for the NIC datapath. It sits between the RX queues and the output queues. Packets pass through an internal fallthrough FIFO, and each packet's destination port byte in TUSER is optionally overridden. After a programmable idle period the block emits an optional LPI marker frame and runs a SLEEP / QUIET / WAKE timer sequence. It reports LPI statistics.

---
 rtl/nf10_eee_lpi_port_lookup.sv | 250 +++++++++++++++++++++++++
 tb/tb_nf10_eee_lpi_port_lookup.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf10_eee_lpi_port_lookup.sv
// -----------------------------------------------------------------------------
// nf10_eee_lpi_port_lookup
//
// Energy-Efficient-Ethernet output stage. Packets are buffered in a small
// fallthrough FIFO and forwarded on the master stream. The destination-port
// byte in TUSER can be forced to dst_port_cfg. After a programmable idle
// period the block can emit a one-beat LPI marker frame. It then runs a
// SLEEP / QUIET / WAKE timer sequence. While that sequence runs, incoming
// traffic keeps buffering and the slave side only sees backpressure.
//
// Ports:
//   axi_aclk, axi_resetn        clock, asynchronous active-low reset
//   s_axis_*                    slave AXI-Stream (data, strobes, user, last)
//   m_axis_*                    master AXI-Stream (data, strobes, user, last)
//   lpi_en                      level enable for LPI entry
//   dst_port_cfg                destination-port byte, used when DST_OVERRIDE=1
//   lpi_active                  high in SLEEP, QUIET and WAKE
//   lpi_state                   state index: 0 ACTIVE, 1 MARKER, 2 SLEEP,
//                               3 QUIET, 4 WAKE
//   stat_lpi_entries            saturating count of SLEEP entries
//   stat_quiet_cycles           saturating count of cycles spent in QUIET
// -----------------------------------------------------------------------------
module nf10_eee_lpi_port_lookup #(
  parameter int         C_M_AXIS_DATA_WIDTH  = 256,
  parameter int         C_S_AXIS_DATA_WIDTH  = 256,
  parameter int         C_M_AXIS_TUSER_WIDTH = 128,
  parameter int         C_S_AXIS_TUSER_WIDTH = 128,
  parameter int         SRC_PORT_POS         = 16,
  parameter int         DST_PORT_POS         = 24,
  parameter int         FIFO_DEPTH_BITS      = 2,
  parameter int         TIMER_WIDTH          = 16,
  parameter int         IDLE_CYCLES          = 16,
  parameter int         T_SLEEP              = 461,
  parameter int         T_QUIET_MIN          = 717,
  parameter int         T_WAKE               = 6349,
  parameter int         SEND_MARKER          = 1,
  parameter logic [7:0] MARKER_PORT          = 8'h04,
  parameter int         DST_OVERRIDE         = 0
) (
  input  logic                              axi_aclk,
  input  logic                              axi_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  input  logic                              lpi_en,
  input  logic [7:0]                        dst_port_cfg,
  output logic                              lpi_active,
  output logic [2:0]                        lpi_state,
  output logic [31:0]                       stat_lpi_entries,
  output logic [31:0]                       stat_quiet_cycles
);

  localparam int     DEPTH      = 1 << FIFO_DEPTH_BITS;
  localparam int     CNT_W      = FIFO_DEPTH_BITS + 1;
  localparam int     STRB_W     = C_M_AXIS_DATA_WIDTH / 8;
  localparam int     ENTRY_W    = C_M_AXIS_DATA_WIDTH + STRB_W + C_M_AXIS_TUSER_WIDTH + 1;
  localparam longint TIMER_MAX  = (longint'(1) << TIMER_WIDTH) - 1;
  localparam logic [31:0] MARKER_PATTERN = 32'hEEE0_1D1E;

  // Parameter sanity checks, resolved at elaboration.
  if (C_M_AXIS_DATA_WIDTH != C_S_AXIS_DATA_WIDTH ||
      C_M_AXIS_TUSER_WIDTH != C_S_AXIS_TUSER_WIDTH ||
      C_M_AXIS_DATA_WIDTH < 32 || (C_M_AXIS_DATA_WIDTH % 8) != 0 ||
      SRC_PORT_POS + 8 > C_M_AXIS_TUSER_WIDTH ||
      DST_PORT_POS + 8 > C_M_AXIS_TUSER_WIDTH ||
      C_M_AXIS_TUSER_WIDTH < 16 || FIFO_DEPTH_BITS < 1 ||
      IDLE_CYCLES < 1 || T_SLEEP < 1 || T_QUIET_MIN < 1 || T_WAKE < 1 ||
      longint'(IDLE_CYCLES) > TIMER_MAX || longint'(T_SLEEP) > TIMER_MAX ||
      longint'(T_QUIET_MIN) > TIMER_MAX || longint'(T_WAKE) > TIMER_MAX) begin : g_bad_params
    $error("nf10_eee_lpi_port_lookup: illegal parameter combination");
  end

  // Timers compare against value-1 so each state lasts exactly its count.
  localparam logic [TIMER_WIDTH-1:0] IDLE_LAST  = TIMER_WIDTH'(IDLE_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] SLEEP_LAST = TIMER_WIDTH'(T_SLEEP - 1);
  localparam logic [TIMER_WIDTH-1:0] QUIET_LAST = TIMER_WIDTH'(T_QUIET_MIN - 1);
  localparam logic [TIMER_WIDTH-1:0] WAKE_LAST  = TIMER_WIDTH'(T_WAKE - 1);

  typedef enum logic [2:0] {
    ST_ACTIVE = 3'd0,
    ST_MARKER = 3'd1,
    ST_SLEEP  = 3'd2,
    ST_QUIET  = 3'd3,
    ST_WAKE   = 3'd4
  } state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  state_t                         state;
  logic [TIMER_WIDTH-1:0]         idle_timer;
  logic [TIMER_WIDTH-1:0]         state_timer;
  logic                           in_pkt;

  // ---------------------------------------------------------------- FIFO
  logic [ENTRY_W-1:0]              fifo_mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]                count;
  logic                            fifo_empty, fifo_nearly_full;
  logic                            wr_en, rd_en;
  logic [C_M_AXIS_DATA_WIDTH-1:0]  head_data;
  logic [STRB_W-1:0]               head_strb;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] head_user;
  logic                            head_last;

  assign fifo_empty       = (count == '0);
  // One slot of headroom so upstream sees backpressure before the FIFO is full.
  assign fifo_nearly_full = (count >= CNT_W'(DEPTH - 1));
  assign s_axis_tready    = !fifo_nearly_full;
  assign wr_en            = s_axis_tvalid && !fifo_nearly_full;
  assign rd_en            = (state == ST_ACTIVE) && !fifo_empty && m_axis_tready;

  assign {head_last, head_user, head_strb, head_data} = fifo_mem[rd_ptr];

  // NOTE: the storage array has no reset; emptiness is tracked by the reset
  // pointers and count, so stale contents are never presented as valid.
  always_ff @(posedge axi_aclk) begin
    if (wr_en) fifo_mem[wr_ptr] <= {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + FIFO_DEPTH_BITS'(1);
      if (rd_en) rd_ptr <= rd_ptr + FIFO_DEPTH_BITS'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------- output mux
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = head_data;
    m_axis_tstrb  = head_strb;
    m_axis_tlast  = head_last;
    m_axis_tuser  = head_user;
    if (DST_OVERRIDE != 0) m_axis_tuser[DST_PORT_POS +: 8] = dst_port_cfg;
    case (state)
      ST_ACTIVE: m_axis_tvalid = !fifo_empty;
      ST_MARKER: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = '0;
        m_axis_tdata[C_M_AXIS_DATA_WIDTH-1 -: 32] = MARKER_PATTERN;
        m_axis_tstrb  = '1;
        m_axis_tlast  = 1'b1;
        m_axis_tuser  = '0;
        m_axis_tuser[DST_PORT_POS +: 8] = MARKER_PORT;
        m_axis_tuser[15:0]              = 16'(STRB_W);
      end
      default: ;
    endcase
  end

  assign lpi_state = state;

  // ----------------------------------------------------------------- FSM
  logic idle_cond, wake_req;
  assign idle_cond = fifo_empty && !in_pkt && lpi_en;
  assign wake_req  = !fifo_empty || !lpi_en;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state             <= ST_ACTIVE;
      idle_timer        <= '0;
      state_timer       <= '0;
      in_pkt            <= 1'b0;
      lpi_active        <= 1'b0;
      stat_lpi_entries  <= '0;
      stat_quiet_cycles <= '0;
    end else begin
      // Saturate so a long QUIET stay cannot wrap the >= comparison.
      state_timer <= (state_timer == '1) ? state_timer : state_timer + TIMER_WIDTH'(1);
      case (state)
        ST_ACTIVE: begin
          if (rd_en) in_pkt <= !head_last;
          if (!idle_cond) begin
            idle_timer <= '0;
          end else if (idle_timer != IDLE_LAST) begin
            idle_timer <= idle_timer + TIMER_WIDTH'(1);
          end else begin
            idle_timer  <= '0;
            state_timer <= '0;
            if (SEND_MARKER != 0) begin
              state <= ST_MARKER;
            end else begin
              state            <= ST_SLEEP;
              lpi_active       <= 1'b1;
              stat_lpi_entries <= sat_inc(stat_lpi_entries);
            end
          end
        end
        ST_MARKER: begin
          if (m_axis_tready) begin
            state            <= ST_SLEEP;
            state_timer      <= '0;
            lpi_active       <= 1'b1;
            stat_lpi_entries <= sat_inc(stat_lpi_entries);
          end
        end
        ST_SLEEP: begin
          if (state_timer == SLEEP_LAST) begin
            state       <= wake_req ? ST_WAKE : ST_QUIET;
            state_timer <= '0;
          end
        end
        ST_QUIET: begin
          stat_quiet_cycles <= sat_inc(stat_quiet_cycles);
          if (state_timer >= QUIET_LAST && wake_req) begin
            state       <= ST_WAKE;
            state_timer <= '0;
          end
        end
        ST_WAKE: begin
          if (state_timer == WAKE_LAST) begin
            state       <= ST_ACTIVE;
            state_timer <= '0;
            idle_timer  <= '0;
            lpi_active  <= 1'b0;
          end
        end
        default: begin
          state       <= ST_ACTIVE;
          state_timer <= '0;
          lpi_active  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nf10_eee_lpi_port_lookup.sv
// -----------------------------------------------------------------------------
// tb_nf10_eee_lpi_port_lookup
//
// Directed bench for nf10_eee_lpi_port_lookup with default timers and
// DST_OVERRIDE=1. Stimulus pushes every expected output beat into a queue.
// A monitor on the falling edge pops and compares each accepted master beat.
// State, timing and statistics are checked inline at exact cycle offsets.
// -----------------------------------------------------------------------------
module tb_nf10_eee_lpi_port_lookup;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  strb;
    logic [127:0] user;
    logic         last;
  } beat_t;

  localparam logic [7:0]   CFG_PORT   = 8'h10;
  // Input sideband: misc 16'hBEEF, dst 8'h33, src 8'h21, length 16'h0040.
  localparam logic [127:0] USER_IN    = {80'h0, 16'hBEEF, 8'h33, 8'h21, 16'h0040};
  // Same sideband with the dst byte forced to CFG_PORT.
  localparam logic [127:0] USER_OUT   = {80'h0, 16'hBEEF, 8'h10, 8'h21, 16'h0040};
  localparam logic [255:0] MARK_DATA  = {32'hEEE0_1D1E, 224'h0};
  localparam logic [127:0] MARK_USER  = 128'h0400_0020;

  logic         axi_aclk = 1'b0;
  logic         axi_resetn;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tstrb;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tstrb;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic         lpi_en;
  logic [7:0]   dst_port_cfg;
  logic         lpi_active;
  logic [2:0]   lpi_state;
  logic [31:0]  stat_lpi_entries;
  logic [31:0]  stat_quiet_cycles;

  int    n_vec = 0;
  int    n_err = 0;
  beat_t exp_q[$];

  nf10_eee_lpi_port_lookup #(.DST_OVERRIDE(1)) dut (
    .axi_aclk          (axi_aclk),
    .axi_resetn        (axi_resetn),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tstrb      (s_axis_tstrb),
    .s_axis_tuser      (s_axis_tuser),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .s_axis_tlast      (s_axis_tlast),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tstrb      (m_axis_tstrb),
    .m_axis_tuser      (m_axis_tuser),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tlast      (m_axis_tlast),
    .lpi_en            (lpi_en),
    .dst_port_cfg      (dst_port_cfg),
    .lpi_active        (lpi_active),
    .lpi_state         (lpi_state),
    .stat_lpi_entries  (stat_lpi_entries),
    .stat_quiet_cycles (stat_quiet_cycles)
  );

  always #5 axi_aclk = ~axi_aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance n rising edges and land 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge axi_aclk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (lpi_state !== s && n < budget) begin
      tick(1);
      n++;
    end
    check(name, 64'(lpi_state), 64'(s));
  endtask

  task automatic push_marker();
    beat_t e;
    e.data = MARK_DATA;
    e.strb = 32'hFFFF_FFFF;
    e.user = MARK_USER;
    e.last = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic send_beat(input logic [255:0] d, input logic [31:0] st, input logic l,
                           input logic expect_out);
    int    guard = 0;
    beat_t e;
    if (expect_out) begin
      e.data = d;
      e.strb = st;
      e.user = USER_OUT;
      e.last = l;
      exp_q.push_back(e);
    end
    s_axis_tdata  = d;
    s_axis_tstrb  = st;
    s_axis_tuser  = USER_IN;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && guard < 200) begin
      tick(1);
      guard++;
    end
    if (guard == 200) begin
      n_vec++;
      n_err++;
      $display("FAIL s_axis_tready: got 0 for 200 cycles, expected 1");
    end
    tick(1);
    s_axis_tvalid = 1'b0;
  endtask

  // Scoreboard monitor: compares every accepted master beat.
  always @(negedge axi_aclk) begin : monitor
    beat_t e;
    if (axi_resetn === 1'b1 && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL out_beat: got unexpected beat data=%h, expected no beat", m_axis_tdata);
      end else begin
        e = exp_q.pop_front();
        if (m_axis_tdata !== e.data || m_axis_tstrb !== e.strb ||
            m_axis_tuser !== e.user || m_axis_tlast !== e.last) begin
          n_err++;
          $display("FAIL out_beat: got data=%h strb=%h user=%h last=%b, expected data=%h strb=%h user=%h last=%b",
                   m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast,
                   e.data, e.strb, e.user, e.last);
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    axi_resetn    = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tstrb  = '0;
    s_axis_tuser  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    lpi_en        = 1'b1;
    dst_port_cfg  = CFG_PORT;
    tick(3);

    // Reset values.
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_state", 64'(lpi_state), 64'd0);
    check("rst_active", 64'(lpi_active), 64'd0);
    check("rst_entries", 64'(stat_lpi_entries), 64'd0);
    check("rst_s_tready", 64'(s_axis_tready), 64'd1);

    // Idle entry: marker in cycle 17, SLEEP for 461 cycles, then QUIET.
    axi_resetn = 1'b1;
    push_marker();
    tick(15);
    check("idle_still_active", 64'(lpi_state), 64'd0);
    tick(1);
    check("marker_state", 64'(lpi_state), 64'd1);
    check("marker_tvalid", 64'(m_axis_tvalid), 64'd1);
    tick(1);
    check("sleep_state", 64'(lpi_state), 64'd2);
    check("sleep_active", 64'(lpi_active), 64'd1);
    check("entries_1", 64'(stat_lpi_entries), 64'd1);
    tick(460);
    check("sleep_last_cycle", 64'(lpi_state), 64'd2);
    tick(1);
    check("quiet_state", 64'(lpi_state), 64'd3);

    // Packet arrives after 100 QUIET cycles; QUIET still lasts 717 cycles.
    tick(100);
    send_beat({8{32'h1111_0001}}, 32'hFFFF_FFFF, 1'b1, 1'b1);
    tick(615);
    check("quiet_min_hold", 64'(lpi_state), 64'd3);
    tick(1);
    check("wake_state", 64'(lpi_state), 64'd4);
    check("quiet_cycles_717", 64'(stat_quiet_cycles), 64'd717);
    tick(6348);
    check("wake_last_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("wake_last_state", 64'(lpi_state), 64'd4);
    tick(1);
    check("wake_exit_active", 64'(lpi_state), 64'd0);
    check("wake_exit_lpi", 64'(lpi_active), 64'd0);
    check("wake_exit_tvalid", 64'(m_axis_tvalid), 64'd1);
    lpi_en = 1'b0;
    tick(2);

    // 3-beat packet with a long gap: no LPI entry while mid-packet.
    lpi_en = 1'b1;
    send_beat({8{32'h2222_0001}}, 32'hFFFF_FFFF, 1'b0, 1'b1);
    tick(30);
    check("no_lpi_in_pkt", 64'(lpi_state), 64'd0);
    send_beat({8{32'h2222_0002}}, 32'hFFFF_FFFF, 1'b0, 1'b1);
    send_beat({8{32'h2222_0003}}, 32'h0000_FFFF, 1'b1, 1'b1);
    tick(2);
    check("pkt_drained", 64'(exp_q.size()), 64'd0);

    // Marker held under backpressure, SLEEP only after the handshake.
    m_axis_tready = 1'b0;
    wait_state(3'd1, 40, "marker_reached");
    for (int i = 0; i < 5; i++) begin
      check("marker_hold_state", 64'(lpi_state), 64'd1);
      check("marker_hold_pat", 64'(m_axis_tdata[255:224]), 64'hEEE0_1D1E);
      check("marker_hold_dst", 64'(m_axis_tuser[31:24]), 64'h04);
      tick(1);
    end
    push_marker();
    m_axis_tready = 1'b1;
    tick(1);
    check("marker_to_sleep", 64'(lpi_state), 64'd2);
    check("entries_2", 64'(stat_lpi_entries), 64'd2);

    // Packet mid-SLEEP: SLEEP completes, straight to WAKE, no QUIET.
    tick(100);
    send_beat({8{32'h3333_0001}}, 32'hFFFF_FFFF, 1'b0, 1'b1);
    send_beat({8{32'h3333_0002}}, 32'h0000_00FF, 1'b1, 1'b1);
    tick(358);
    check("mid_sleep_hold", 64'(lpi_state), 64'd2);
    tick(1);
    check("sleep_to_wake", 64'(lpi_state), 64'd4);
    check("no_quiet_cycles", 64'(stat_quiet_cycles), 64'd717);
    tick(6349);
    check("wake2_exit", 64'(lpi_state), 64'd0);

    // Reset mid-WAKE with two beats buffered.
    push_marker();
    wait_state(3'd2, 100, "sleep3_reached");
    send_beat({8{32'h4444_0001}}, 32'hFFFF_FFFF, 1'b0, 1'b0);
    send_beat({8{32'h4444_0002}}, 32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_state(3'd4, 600, "wake3_reached");
    check("entries_3", 64'(stat_lpi_entries), 64'd3);
    tick(100);
    axi_resetn = 1'b0;
    #1;
    check("arst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("arst_active", 64'(lpi_active), 64'd0);
    check("arst_state", 64'(lpi_state), 64'd0);
    check("arst_entries", 64'(stat_lpi_entries), 64'd0);
    check("arst_quiet", 64'(stat_quiet_cycles), 64'd0);
    lpi_en = 1'b0;
    tick(2);
    axi_resetn = 1'b1;
    tick(3);
    check("post_rst_state", 64'(lpi_state), 64'd0);
    check("post_rst_empty", 64'(m_axis_tvalid), 64'd0);
    check("post_rst_s_tready", 64'(s_axis_tready), 64'd1);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
